ex_mem_stage: RTL and testbench

- Downstream consumer of the ID/EX pipeline register.
- Takes the ID/EX bundle (pc, operands, immediate, register indices, funct, control bits) and resolves forwarding, the ALU operation and the branch condition.
- Captures results in the EX/MEM pipeline register with stall/flush control.
- Drives the memory stage and feeds branch redirect and forwarding information back upstream.

---
 rtl/ex_pkg.sv | 54 +++++
 rtl/alu_64.sv | 34 +++
 rtl/ex_mem_stage.sv | 149 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU control codes, funct and branch codes,
// the internal ALU operation type and the decoder that maps control bits onto it.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b1000;
  localparam logic [3:0] FUNCT_AND = 4'b0111;
  localparam logic [3:0] FUNCT_OR  = 4'b0110;
  localparam logic [3:0] FUNCT_XOR = 4'b0100;
  localparam logic [3:0] FUNCT_SLL = 4'b0001;
  localparam logic [3:0] FUNCT_SRL = 4'b0101;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b110;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL
  } alu_op_e;

  // The reserved aluop code and unknown funct values both fall back to add.
  function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [3:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    if (aluop == ALUOP_SUB) begin
      op = ALU_SUB;
    end else if (aluop == ALUOP_FUNCT) begin
      case (funct)
        FUNCT_ADD: op = ALU_ADD;
        FUNCT_SUB: op = ALU_SUB;
        FUNCT_AND: op = ALU_AND;
        FUNCT_OR:  op = ALU_OR;
        FUNCT_XOR: op = ALU_XOR;
        FUNCT_SLL: op = ALU_SLL;
        FUNCT_SRL: op = ALU_SRL;
        default:   op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/alu_64.sv
// Combinational integer ALU; arithmetic wraps modulo 2^XLEN and shifts use the
// low log2(XLEN) bits of b as the shift amount.
module alu_64
  import ex_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM
// pipeline register with reset > flush > stall > load priority.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] idexpc_out,
  input  logic [XLEN-1:0] idexreaddata1,
  input  logic [XLEN-1:0] idexreaddata2,
  input  logic [XLEN-1:0] ideximm,
  input  logic [RA_W-1:0] idexrs1,
  input  logic [RA_W-1:0] idexrs2,
  input  logic [RA_W-1:0] idexrd,
  input  logic [3:0]      idexfunct3,
  input  logic            idexbranch,
  input  logic            idexmemread,
  input  logic            idexmemtoreg,
  input  logic            idexmemwrite,
  input  logic            idexregwrite,
  input  logic            idexalusrc,
  input  logic [1:0]      idexaluop,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_regwrite,
  input  logic [XLEN-1:0] memwb_writedata,
  output logic [XLEN-1:0] exmem_aluresult,
  output logic [XLEN-1:0] exmem_writedata,
  output logic [RA_W-1:0] exmem_rd,
  output logic [XLEN-1:0] exmem_branch_target,
  output logic            exmem_branch_taken,
  output logic            exmem_memread,
  output logic            exmem_memwrite,
  output logic            exmem_memtoreg,
  output logic            exmem_regwrite
);

  logic [XLEN-1:0] aluresult_d, aluresult_q, writedata_d, writedata_q;
  logic [XLEN-1:0] target_d, target_q;
  logic [RA_W-1:0] rd_d, rd_q;
  logic            taken_d, taken_q, memread_d, memread_q, memwrite_d, memwrite_q;
  logic            memtoreg_d, memtoreg_q, regwrite_d, regwrite_q;

  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_result;
  logic            ex_fwd_ok, wb_fwd_ok, br_cond;

  // A load in EX/MEM has no data yet, so only non-load results are forwarded from it.
  always_comb begin
    ex_fwd_ok = regwrite_q && !memtoreg_q && (rd_q != '0);
    wb_fwd_ok = memwb_regwrite && (memwb_rd != '0);
    fwd_a = idexreaddata1;
    fwd_b = idexreaddata2;
    if (ex_fwd_ok && (rd_q == idexrs1))          fwd_a = aluresult_q;
    else if (wb_fwd_ok && (memwb_rd == idexrs1)) fwd_a = memwb_writedata;
    if (ex_fwd_ok && (rd_q == idexrs2))          fwd_b = aluresult_q;
    else if (wb_fwd_ok && (memwb_rd == idexrs2)) fwd_b = memwb_writedata;
    alu_b = idexalusrc ? ideximm : fwd_b;
  end

  alu_64 #(.XLEN(XLEN)) u_alu (
    .a      (fwd_a),
    .b      (alu_b),
    .op     (alu_decode(idexaluop, idexfunct3)),
    .result (alu_result)
  );

  always_comb begin
    br_cond = 1'b0;
    case (idexfunct3[2:0])
      BR_BEQ:  br_cond = (fwd_a == fwd_b);
      BR_BNE:  br_cond = (fwd_a != fwd_b);
      BR_BLT:  br_cond = ($signed(fwd_a) < $signed(fwd_b));
      BR_BLTU: br_cond = (fwd_a < fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    aluresult_d = alu_result;
    writedata_d = fwd_b;
    target_d    = idexpc_out + ideximm;
    rd_d        = idexrd;
    taken_d     = idexbranch && br_cond;
    memread_d   = idexmemread;
    memwrite_d  = idexmemwrite;
    memtoreg_d  = idexmemtoreg;
    regwrite_d  = idexregwrite;
    if (flush) begin
      aluresult_d = '0;
      writedata_d = '0;
      target_d    = '0;
      rd_d        = '0;
      taken_d     = 1'b0;
      memread_d   = 1'b0;
      memwrite_d  = 1'b0;
      memtoreg_d  = 1'b0;
      regwrite_d  = 1'b0;
    end else if (stall) begin
      aluresult_d = aluresult_q;
      writedata_d = writedata_q;
      target_d    = target_q;
      rd_d        = rd_q;
      taken_d     = taken_q;
      memread_d   = memread_q;
      memwrite_d  = memwrite_q;
      memtoreg_d  = memtoreg_q;
      regwrite_d  = regwrite_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aluresult_q <= '0;
      writedata_q <= '0;
      target_q    <= '0;
      rd_q        <= '0;
      taken_q     <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      regwrite_q  <= 1'b0;
    end else begin
      aluresult_q <= aluresult_d;
      writedata_q <= writedata_d;
      target_q    <= target_d;
      rd_q        <= rd_d;
      taken_q     <= taken_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      memtoreg_q  <= memtoreg_d;
      regwrite_q  <= regwrite_d;
    end
  end

  assign exmem_aluresult     = aluresult_q;
  assign exmem_writedata     = writedata_q;
  assign exmem_rd            = rd_q;
  assign exmem_branch_target = target_q;
  assign exmem_branch_taken  = taken_q;
  assign exmem_memread       = memread_q;
  assign exmem_memwrite      = memwrite_q;
  assign exmem_memtoreg      = memtoreg_q;
  assign exmem_regwrite      = regwrite_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a reference model predicts the EX/MEM register
// every cycle, and directed scenarios add fixed-value checks on top.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [63:0] alu;
    logic [63:0] wdata;
    logic [63:0] tgt;
    logic [4:0]  rd;
    logic        taken;
    logic        mr;
    logic        mw;
    logic        mtr;
    logic        rw;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [63:0] idexpc_out, idexreaddata1, idexreaddata2, ideximm;
  logic [4:0]  idexrs1, idexrs2, idexrd;
  logic [3:0]  idexfunct3;
  logic        idexbranch, idexmemread, idexmemtoreg, idexmemwrite, idexregwrite, idexalusrc;
  logic [1:0]  idexaluop;
  logic [4:0]  memwb_rd;
  logic        memwb_regwrite;
  logic [63:0] memwb_writedata;
  logic [63:0] exmem_aluresult, exmem_writedata, exmem_branch_target;
  logic [4:0]  exmem_rd;
  logic        exmem_branch_taken, exmem_memread, exmem_memwrite, exmem_memtoreg, exmem_regwrite;

  exp_t model_q;
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .idexpc_out(idexpc_out), .idexreaddata1(idexreaddata1), .idexreaddata2(idexreaddata2),
    .ideximm(ideximm), .idexrs1(idexrs1), .idexrs2(idexrs2), .idexrd(idexrd),
    .idexfunct3(idexfunct3), .idexbranch(idexbranch), .idexmemread(idexmemread),
    .idexmemtoreg(idexmemtoreg), .idexmemwrite(idexmemwrite), .idexregwrite(idexregwrite),
    .idexalusrc(idexalusrc), .idexaluop(idexaluop),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_writedata(memwb_writedata),
    .exmem_aluresult(exmem_aluresult), .exmem_writedata(exmem_writedata), .exmem_rd(exmem_rd),
    .exmem_branch_target(exmem_branch_target), .exmem_branch_taken(exmem_branch_taken),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_memtoreg(exmem_memtoreg), .exmem_regwrite(exmem_regwrite)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] refAlu(input logic [1:0] aluop, input logic [3:0] funct,
                                         input logic [63:0] a, input logic [63:0] b);
    if (aluop == 2'b01) return a - b;
    if (aluop != 2'b10) return a + b;
    case (funct)
      4'b1000: return a - b;
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0100: return a ^ b;
      4'b0001: return a << b[5:0];
      4'b0101: return a >> b[5:0];
      default: return a + b;
    endcase
  endfunction

  function automatic logic [63:0] refFwd(input logic [4:0] rs, input logic [63:0] regval);
    if (model_q.rw && !model_q.mtr && model_q.rd != 5'd0 && model_q.rd == rs) return model_q.alu;
    if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs) return memwb_writedata;
    return regval;
  endfunction

  function automatic exp_t modelNext();
    exp_t e;
    logic [63:0] a, b;
    logic cond;
    e = '0;
    if (reset || flush) return e;
    if (stall) return model_q;
    a = refFwd(idexrs1, idexreaddata1);
    b = refFwd(idexrs2, idexreaddata2);
    case (idexfunct3[2:0])
      3'b000:  cond = (a == b);
      3'b001:  cond = (a != b);
      3'b100:  cond = ($signed(a) < $signed(b));
      3'b110:  cond = (a < b);
      default: cond = 1'b0;
    endcase
    e.alu   = refAlu(idexaluop, idexfunct3, a, idexalusrc ? ideximm : b);
    e.wdata = b;
    e.tgt   = idexpc_out + ideximm;
    e.rd    = idexrd;
    e.taken = idexbranch & cond;
    e.mr    = idexmemread;
    e.mw    = idexmemwrite;
    e.mtr   = idexmemtoreg;
    e.rw    = idexregwrite;
    return e;
  endfunction

  // Predict, clock one edge, then pop the prediction and compare every field.
  task automatic applyStimulus(input string tag);
    exp_t e;
    e = modelNext();
    model_q = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_sb: got=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_alu"}, exmem_aluresult, e.alu);
      checkOutput({tag, "_wdata"}, exmem_writedata, e.wdata);
      checkOutput({tag, "_tgt"}, exmem_branch_target, e.tgt);
      checkOutput({tag, "_rd"}, {59'd0, exmem_rd}, {59'd0, e.rd});
      checkOutput({tag, "_ctl"},
                  {59'd0, exmem_branch_taken, exmem_memread, exmem_memwrite, exmem_memtoreg, exmem_regwrite},
                  {59'd0, e.taken, e.mr, e.mw, e.mtr, e.rw});
    end
  endtask

  task automatic clearCtrl();
    reset = 0; stall = 0; flush = 0;
    idexbranch = 0; idexmemread = 0; idexmemtoreg = 0; idexmemwrite = 0;
    idexregwrite = 0; idexalusrc = 0; idexaluop = 2'b00; idexfunct3 = 4'b0000;
    memwb_regwrite = 0; memwb_rd = 5'd0; memwb_writedata = 64'd0;
    idexpc_out = 64'd0; ideximm = 64'd0; idexrd = 5'd0;
  endtask

  initial begin
    model_q = '0;
    clearCtrl();
    // Reset with busy inputs, including stall and flush, must still clear everything.
    reset = 1; stall = 1;
    idexreaddata1 = 64'h1234; idexreaddata2 = 64'h99; ideximm = 64'h8; idexpc_out = 64'h100;
    idexrs1 = 5'd1; idexrs2 = 5'd2; idexrd = 5'd3; idexregwrite = 1; idexmemwrite = 1;
    idexbranch = 1; idexmemread = 1;
    applyStimulus("rst0");
    stall = 0; flush = 1;
    applyStimulus("rst1");
    checkOutput("rst_alu", exmem_aluresult, 64'd0);
    checkOutput("rst_regwrite", {63'd0, exmem_regwrite}, 64'd0);
    checkOutput("rst_memwrite", {63'd0, exmem_memwrite}, 64'd0);

    // R-type sub, first instruction after reset.
    clearCtrl();
    idexreaddata1 = 64'd10; idexreaddata2 = 64'd3; idexrs1 = 5'd1; idexrs2 = 5'd2;
    idexrd = 5'd7; idexaluop = 2'b10; idexfunct3 = 4'b1000; idexregwrite = 1;
    applyStimulus("sub");
    checkOutput("sub_result", exmem_aluresult, 64'd7);
    checkOutput("sub_regwrite", {63'd0, exmem_regwrite}, 64'd1);
    checkOutput("sub_memwrite", {63'd0, exmem_memwrite}, 64'd0);

    // x5 = 100 enters EX/MEM, then a dependent addi must see it over MEM/WB's 55.
    clearCtrl();
    idexrs1 = 5'd1; idexrs2 = 5'd2; idexreaddata1 = 64'd100; idexalusrc = 1;
    idexrd = 5'd5; idexregwrite = 1;
    applyStimulus("wr_x5");
    idexrs1 = 5'd5; idexreaddata1 = 64'd999; ideximm = 64'd1; idexrd = 5'd6;
    memwb_rd = 5'd5; memwb_regwrite = 1; memwb_writedata = 64'd55;
    applyStimulus("fwd_ex");
    checkOutput("fwd_ex_prio", exmem_aluresult, 64'd101);
    applyStimulus("fwd_wb");
    checkOutput("fwd_wb_only", exmem_aluresult, 64'd56);

    // Writes to x0 are never forwarded from either stage.
    clearCtrl();
    idexrs1 = 5'd1; idexreaddata1 = 64'd100; idexalusrc = 1; idexrd = 5'd0; idexregwrite = 1;
    applyStimulus("wr_x0");
    idexrs1 = 5'd0; idexreaddata1 = 64'd3; ideximm = 64'd1; idexrd = 5'd8;
    memwb_rd = 5'd0; memwb_regwrite = 1; memwb_writedata = 64'd55;
    applyStimulus("fwd_x0");
    checkOutput("fwd_x0_none", exmem_aluresult, 64'd4);

    // Branches.
    clearCtrl();
    idexrs1 = 5'd10; idexrs2 = 5'd11; idexbranch = 1; idexaluop = 2'b01;
    idexreaddata1 = 64'd8; idexreaddata2 = 64'd8; idexpc_out = 64'h40; ideximm = 64'h10;
    idexfunct3 = 4'b0000;
    applyStimulus("beq");
    checkOutput("beq_taken", {63'd0, exmem_branch_taken}, 64'd1);
    checkOutput("beq_target", exmem_branch_target, 64'h50);
    stall = 1; idexbranch = 0; idexpc_out = 64'h80;
    applyStimulus("beq_stall");
    checkOutput("beq_stall_taken", {63'd0, exmem_branch_taken}, 64'd1);
    stall = 0; idexbranch = 1; idexfunct3 = 4'b0001;
    applyStimulus("bne");
    checkOutput("bne_taken", {63'd0, exmem_branch_taken}, 64'd0);
    idexreaddata1 = '1; idexreaddata2 = 64'd1; idexfunct3 = 4'b0100;
    applyStimulus("blt");
    checkOutput("blt_taken", {63'd0, exmem_branch_taken}, 64'd1);
    idexfunct3 = 4'b0110;
    applyStimulus("bltu");
    checkOutput("bltu_taken", {63'd0, exmem_branch_taken}, 64'd0);

    // Store with data forwarded from MEM/WB, then stall three cycles, then flush+stall.
    clearCtrl();
    idexrs1 = 5'd12; idexreaddata1 = 64'h1000; idexrs2 = 5'd13; idexreaddata2 = 64'h1;
    ideximm = 64'd8; idexalusrc = 1; idexmemwrite = 1; idexrd = 5'd0;
    memwb_rd = 5'd13; memwb_regwrite = 1; memwb_writedata = 64'hDEAD;
    applyStimulus("sd");
    checkOutput("sd_wdata", exmem_writedata, 64'hDEAD);
    checkOutput("sd_addr", exmem_aluresult, 64'h1008);
    for (int i = 0; i < 3; i++) begin
      stall = 1; idexreaddata1 = 64'h5000 + 64'(i); idexmemwrite = 0; idexregwrite = 1;
      applyStimulus("stall");
      checkOutput("stall_addr", exmem_aluresult, 64'h1008);
      checkOutput("stall_memwrite", {63'd0, exmem_memwrite}, 64'd1);
    end
    flush = 1;
    applyStimulus("flush");
    checkOutput("flush_memwrite", {63'd0, exmem_memwrite}, 64'd0);
    checkOutput("flush_regwrite", {63'd0, exmem_regwrite}, 64'd0);

    // Random traffic with small register indices so forwarding paths collide often.
    for (int i = 0; i < 60; i++) begin
      reset = ($urandom_range(0, 29) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 7) == 0);
      idexpc_out = {$urandom, $urandom}; idexreaddata1 = {$urandom, $urandom};
      idexreaddata2 = {$urandom, $urandom}; ideximm = 64'($urandom_range(0, 200));
      if ($urandom_range(0, 3) == 0) idexreaddata1 = idexreaddata2;
      idexrs1 = 5'($urandom_range(0, 3)); idexrs2 = 5'($urandom_range(0, 3));
      idexrd = 5'($urandom_range(0, 3)); idexfunct3 = 4'($urandom_range(0, 15));
      idexaluop = 2'($urandom_range(0, 3)); idexbranch = 1'($urandom);
      idexmemread = 1'($urandom); idexmemtoreg = 1'($urandom); idexmemwrite = 1'($urandom);
      idexregwrite = 1'($urandom); idexalusrc = 1'($urandom);
      memwb_rd = 5'($urandom_range(0, 3)); memwb_regwrite = 1'($urandom);
      memwb_writedata = {$urandom, $urandom};
      applyStimulus("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
